// File: rtl/ucode_loader.sv
// Microcode control-store loader: byte-serial frames (header, N words LSB-first, optional checksum) written into a 1R1W store.
// Build option UCODE_CHECKSUM_EN adds the trailing XOR checksum byte and the sticky err flag.
module ucode_loader #(
  parameter int WORD_BYTES = 4,
  parameter int ADDR_W     = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [7:0]              ld_data,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [8*WORD_BYTES-1:0] rd_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int WW = 8 * WORD_BYTES;
  localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  typedef enum logic [1:0] {S_HDR, S_DATA, S_CSUM, S_DONE} state_t;

  state_t            state, state_nx;
  logic [BW-1:0]     byte_cnt;
  logic [2:0]        word_cnt;
  logic [2:0]        word_last;
  logic [ADDR_W-1:0] start;
  logic [WW-1:0]     word_buf;
  logic [WW-1:0]     word_nx;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WW-1:0]     wr_data;
  logic              accept;
  logic              last_byte;
  logic              last_word;

  logic [WW-1:0] mem [2**ADDR_W];

  assign ld_ready  = (state != S_DONE);
  assign busy      = (state != S_HDR);
  assign done      = (state == S_DONE);
  assign accept    = ld_valid & ld_ready;
  assign last_byte = (byte_cnt == BW'(WORD_BYTES - 1));
  assign last_word = (word_cnt == word_last);

  // Incoming byte merged into the word being assembled.
  always_comb begin
    word_nx = word_buf;
    word_nx[{byte_cnt, 3'b000} +: 8] = ld_data;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_HDR:  if (accept) state_nx = S_DATA;
      S_DATA: if (accept && last_byte && last_word) begin
`ifdef UCODE_CHECKSUM_EN
        state_nx = S_CSUM;
`else
        state_nx = S_DONE;
`endif
      end
`ifdef UCODE_CHECKSUM_EN
      S_CSUM: if (accept) state_nx = S_DONE;
`endif
      S_DONE: state_nx = S_HDR;
      default: state_nx = S_HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_HDR;
      byte_cnt <= '0;
      word_cnt <= '0;
      wr_en    <= 1'b0;
    end else begin
      state <= state_nx;
      wr_en <= 1'b0;
      if (accept) begin
        case (state)
          S_HDR: begin
            start     <= ADDR_W'(ld_data[4:0]);
            word_last <= ld_data[7:5];
            word_cnt  <= '0;
            byte_cnt  <= '0;
          end
          S_DATA: begin
            word_buf <= word_nx;
            if (last_byte) begin
              // Only complete words are committed; the write lands one cycle later.
              byte_cnt <= '0;
              word_cnt <= word_cnt + 3'd1;
              wr_en    <= 1'b1;
              wr_addr  <= start + ADDR_W'(word_cnt);
              wr_data  <= word_nx;
            end else begin
              byte_cnt <= byte_cnt + BW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef UCODE_CHECKSUM_EN
  logic [7:0] csum;
  logic       err_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_q <= 1'b0;
      csum  <= '0;
    end else if (accept) begin
      case (state)
        S_HDR:   csum <= ld_data;
        S_DATA:  csum <= csum ^ ld_data;
        S_CSUM:  if (ld_data != csum) err_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Store is not reset; a write already pending when reset hits still completes.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_ucode_loader.sv
// Bench for ucode_loader: frame-position reference model checked every cycle, plus directed literal checks.
module tb_ucode_loader;
  localparam int WB    = 4;
  localparam int AW    = 5;
  localparam int WW    = 8 * WB;
  localparam int DEPTH = 2 ** AW;
`ifdef UCODE_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ld_valid = 1'b0;
  logic [7:0]    ld_data = 8'h00;
  logic [AW-1:0] rd_addr = '0;
  logic          ld_ready;
  logic [WW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic          err;

  ucode_loader #(.WORD_BYTES(WB), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int done_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: tracks position within the frame and a pending word write.
  logic [WW-1:0] m_store [DEPTH];
  bit            m_known [DEPTH];
  int            m_pos = 0;
  int            m_n = 1;
  logic [AW-1:0] m_start = '0;
  bit            m_done = 0;
  logic [WW-1:0] m_acc = '0;
  bit            m_pend = 0;
  logic [AW-1:0] m_paddr = '0;
  logic [WW-1:0] m_pdata = '0;
  logic [WW-1:0] m_rd = '0;
  bit            m_rd_known = 0;
  bit            m_err = 0;
  logic [7:0]    m_csum = 8'h00;
  bit            live = 0;

  always @(posedge clk) begin
    if (!reset) begin
      if (m_pend) begin m_store[m_paddr] = m_pdata; m_known[m_paddr] = 1; end
      m_pend = 0; m_pos = 0; m_done = 0; m_rd = '0; m_rd_known = 1; m_err = 0; live = 1;
    end else if (live) begin
      m_rd_known = m_known[rd_addr];
      m_rd       = m_store[rd_addr];
      if (m_pend) begin m_store[m_paddr] = m_pdata; m_known[m_paddr] = 1; end
      m_pend = 0;
      if (m_done) begin
        m_done = 0;
      end else if (ld_valid) begin
        if (m_pos == 0) begin
          m_start = ld_data[4:0];
          m_n     = int'(ld_data[7:5]) + 1;
          m_csum  = ld_data;
          m_pos   = 1;
        end else if (m_pos <= m_n * WB) begin
          m_acc[((m_pos - 1) % WB) * 8 +: 8] = ld_data;
          m_csum = m_csum ^ ld_data;
          if (m_pos % WB == 0) begin
            m_pend  = 1;
            m_paddr = m_start + AW'(m_pos / WB - 1);
            m_pdata = m_acc;
          end
          if (m_pos == m_n * WB && !CS_EN) begin m_pos = 0; m_done = 1; end
          else m_pos++;
        end else begin
          if (ld_data != m_csum) m_err = 1;
          m_pos = 0;
          m_done = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (live && reset) begin
      chk("ld_ready", ld_ready, !m_done);
      chk("done", done, m_done);
      chk("busy", busy, m_done || m_pos > 0);
      chk("err", err, m_err);
      if (m_rd_known) chk("rd_data", rd_data, m_rd);
      if (done) done_seen++;
    end
  end

  logic [WW-1:0] fw [8];
  logic [WW-1:0] rd_snap;
  bit            rnd_rd = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rnd_rd) rd_addr = AW'($urandom);
  endtask

  task automatic put(input logic [7:0] b);
    int g = 0;
    ld_valid = 1'b1;
    ld_data  = b;
    while (!ld_ready && g < 20) begin cyc(); g++; end
    if (g >= 20) begin
      vectors++; miscompares++;
      $display("FAIL ld_ready_timeout: got 0, expected 1");
    end
    cyc();
    ld_valid = 1'b0;
  endtask

  task automatic frame(input logic [7:0] hdr, input bit gaps, input bit bad_cs);
    logic [7:0] cs;
    logic [7:0] b;
    int n;
    cs = hdr;
    n  = int'(hdr[7:5]) + 1;
    put(hdr);
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < WB; k++) begin
        b = fw[w][k*8 +: 8];
        if (gaps) cyc();
        put(b);
        cs = cs ^ b;
      end
    end
    if (CS_EN) put(cs ^ {7'd0, bad_cs});
    cyc();
    rd_snap = rd_data;
    cyc();
  endtask

  task automatic check_rd(input logic [AW-1:0] a, input logic [WW-1:0] exp, input string name);
    rd_addr = a;
    cyc();
    chk(name, rd_data, exp);
  endtask

  initial begin
    int d0;
    repeat (3) cyc();
    chk("reset_rd_data", rd_data, 0);
    chk("reset_done", done, 0);
    chk("reset_busy", busy, 0);
    chk("reset_err", err, 0);
    reset = 1'b1;
    chk("ready_after_reset", ld_ready, 1);

    for (int base = 0; base < DEPTH; base += 8) begin
      for (int i = 0; i < 8; i++) fw[i] = $urandom;
      frame({3'd7, 5'(base)}, 0, 0);
    end

    fw[0] = 32'h44332211;
    d0 = done_seen;
    frame(8'h03, 0, 0);
    chk("single_done_pulse", done_seen - d0, 1);
    check_rd(5'd3, 32'h44332211, "basic_word");

    fw[0] = 32'hCAFEF00D; fw[1] = 32'h0BADBEEF;
    frame(8'h3F, 0, 0);
    check_rd(5'd31, 32'hCAFEF00D, "wrap_top");
    check_rd(5'd0, 32'h0BADBEEF, "wrap_zero");

    fw[0] = 32'h01020304; fw[1] = 32'hA5A55A5A; fw[2] = 32'hFFFF0000;
    frame(8'h4A, 1, 0);
    check_rd(5'd10, 32'h01020304, "gapped_w0");
    check_rd(5'd11, 32'hA5A55A5A, "gapped_w1");
    check_rd(5'd12, 32'hFFFF0000, "gapped_w2");

    fw[0] = 32'h66666666;
    frame(8'h06, 0, 0);
    d0 = done_seen;
    put(8'h25);
    for (int i = 1; i <= 6; i++) put(8'(i));
    reset = 1'b0;
    cyc();
    chk("abort_ready", ld_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    reset = 1'b1;
    chk("abort_no_done", done_seen - d0, 0);
    check_rd(5'd5, 32'h04030201, "abort_committed");
    check_rd(5'd6, 32'h66666666, "abort_partial_dropped");

    fw[0] = 32'h77770001;
    frame(8'h07, 0, 0);
    rd_addr = 5'd7;
    fw[0] = 32'h77770002;
    frame(8'h07, 0, 0);
    chk("collide_old", rd_snap, 32'h77770001);
    chk("collide_new", rd_data, 32'h77770002);

`ifdef UCODE_CHECKSUM_EN
    fw[0] = 32'h12345678;
    frame(8'h01, 0, 0);
    chk("csum_good_err", err, 0);
    frame(8'h01, 0, 1);
    chk("csum_bad_err", err, 1);
    frame(8'h01, 0, 0);
    chk("csum_sticky_err", err, 1);
`endif

    rnd_rd = 1;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 8; i++) fw[i] = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        put(8'($urandom));
        repeat ($urandom_range(0, 12)) put(8'($urandom));
        reset = 1'b0;
        cyc();
        reset = 1'b1;
      end else begin
        frame(8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
      end
    end
    rnd_rd = 0;
    repeat (4) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
